// File: rtl/program_fetch_arbiter_if.sv
// Fetch/debug/ROM signal bundle for program_fetch_arbiter.
// master = core, debug port and ROM side; slave = the arbiter.
interface program_fetch_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  stall_i;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_addr;
    logic                  dbg_req;
    logic [DATA_WIDTH-1:0] dbg_addr;
    logic                  dbg_ack;
    logic [DATA_WIDTH-1:0] dbg_data;
    logic [DATA_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_instruction;
    logic [DATA_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] instr_o;
    logic                  instr_valid;
    logic                  fetch_fault;

    modport master (
        output stall_i, redirect_valid, redirect_addr,
        output dbg_req, dbg_addr, mem_instruction,
        input  dbg_ack, dbg_data, mem_address,
        input  pc_o, instr_o, instr_valid, fetch_fault
    );

    modport slave (
        input  stall_i, redirect_valid, redirect_addr,
        input  dbg_req, dbg_addr, mem_instruction,
        output dbg_ack, dbg_data, mem_address,
        output pc_o, instr_o, instr_valid, fetch_fault
    );
endinterface

// File: rtl/program_fetch_arbiter.sv
// PC owner and single-port ROM arbiter between instruction fetch
// and a debug readback port, with a registered IF output stage.
module program_fetch_arbiter #(
    parameter int                DATA_WIDTH   = 32,
    parameter int                MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0040_0000
) (
    input logic                 clk,
    input logic                 reset,
    program_fetch_arbiter_if.slave bus
);
    typedef enum logic {GNT_FETCH, GNT_DEBUG} grant_t;

    localparam logic [DATA_WIDTH-1:0] LIMIT = DATA_WIDTH'(4 * MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] ALIGN = ~(DATA_WIDTH'(3));

    grant_t                r_last_grant;
    grant_t                w_next_grant;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_pc_o;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_valid;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_dbg_data;
    logic                  r_fault;

    logic                  w_dbg_elig;
    logic                  w_grant_dbg;
    logic [DATA_WIDTH-1:0] w_fetch_off;
    logic                  w_fetch_oor;
    logic                  w_dbg_oor;
    logic [DATA_WIDTH-1:0] w_addr;

    // Grant state register
    always_ff @(posedge clk) begin
        if (!reset) r_last_grant <= GNT_FETCH;
        else        r_last_grant <= w_next_grant;
    end

    always_comb begin
        w_next_grant = GNT_FETCH;
        if (w_grant_dbg) w_next_grant = GNT_DEBUG;
    end

    // Ack gating keeps a slow-dropping requester from a second service
    always_comb begin
        w_dbg_elig  = bus.dbg_req & ~r_ack;
        w_grant_dbg = w_dbg_elig &
                      (bus.stall_i | (r_last_grant == GNT_FETCH) | r_fault);
    end

    assign w_fetch_off     = r_pc - RESET_VECTOR;
    assign w_fetch_oor     = (w_fetch_off >= LIMIT);
    assign w_dbg_oor       = (bus.dbg_addr >= LIMIT);
    assign w_addr          = w_grant_dbg ? bus.dbg_addr : w_fetch_off;
    assign bus.mem_address = w_addr & ALIGN;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= RESET_VECTOR;
            r_pc_o     <= RESET_VECTOR;
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_ack      <= 1'b0;
            r_dbg_data <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_grant_dbg) begin
                r_ack      <= 1'b1;
                r_dbg_data <= w_dbg_oor ? '0 : bus.mem_instruction;
            end
            // Redirect wins over both stall and the debug bubble
            if (bus.redirect_valid) begin
                r_pc    <= bus.redirect_addr & ALIGN;
                r_valid <= 1'b0;
                r_fault <= 1'b0;
            end else if (w_grant_dbg) begin
                if (!bus.stall_i) r_valid <= 1'b0;
            end else if (bus.stall_i) begin
                r_valid <= r_valid;
            end else if (w_fetch_oor) begin
                r_instr <= '0;
                r_valid <= 1'b0;
                r_fault <= 1'b1;
            end else begin
                r_instr <= bus.mem_instruction;
                r_pc_o  <= r_pc;
                r_valid <= 1'b1;
                r_pc    <= r_pc + DATA_WIDTH'(4);
            end
        end
    end

    assign bus.pc_o        = r_pc_o;
    assign bus.instr_o     = r_instr;
    assign bus.instr_valid = r_valid;
    assign bus.dbg_ack     = r_ack;
    assign bus.dbg_data    = r_dbg_data;
    assign bus.fetch_fault = r_fault;
endmodule

// File: tb/tb_program_fetch_arbiter.sv
// Directed bench for program_fetch_arbiter with a behavioural ROM.
// Inputs change at posedge+1; outputs are sampled at posedge+1.
module tb_program_fetch_arbiter;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    logic [31:0] rom [32];

    program_fetch_arbiter_if #(.DATA_WIDTH(32)) bus ();

    program_fetch_arbiter #(
        .DATA_WIDTH  (32),
        .MEMORY_DEPTH(32),
        .RESET_VECTOR(32'h0040_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Out-of-range reads return junk so zeroing by the DUT is visible
    always_comb begin
        if (bus.mem_address < 32'd128)
            bus.mem_instruction = rom[bus.mem_address[6:2]];
        else
            bus.mem_instruction = 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] pc,
                          input logic [31:0] ins, input logic v);
        chk({tag, ".pc"}, bus.pc_o, pc);
        chk({tag, ".ins"}, bus.instr_o, ins);
        chk({tag, ".v"}, {31'd0, bus.instr_valid}, {31'd0, v});
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rom[0] = 32'h2008_0001;
        rom[1] = 32'h2009_0002;
        rom[2] = 32'h0109_5020;
        rom[3] = 32'h0810_0000;
        for (int i = 4; i < 32; i++) rom[i] = 32'h1000_0000 + i;

        reset = 1'b0;
        bus.stall_i = 0;
        bus.redirect_valid = 0;
        bus.redirect_addr = '0;
        bus.dbg_req = 0;
        bus.dbg_addr = '0;
        step();
        step();
        chk_if("rst", 32'h0040_0000, 32'h0, 1'b0);
        chk("rst.ack", {31'd0, bus.dbg_ack}, 32'd0);
        chk("rst.dd", bus.dbg_data, 32'd0);
        chk("rst.flt", {31'd0, bus.fetch_fault}, 32'd0);
        chk("rst.ma", bus.mem_address, 32'd0);

        reset = 1'b1;
        step();
        chk_if("f0", 32'h0040_0000, 32'h2008_0001, 1'b1);
        step();
        chk_if("f1", 32'h0040_0004, 32'h2009_0002, 1'b1);

        bus.stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_if("stl", 32'h0040_0004, 32'h2009_0002, 1'b1);
        end
        bus.stall_i = 0;
        step();
        chk_if("f2", 32'h0040_0008, 32'h0109_5020, 1'b1);
        step();
        chk_if("f3", 32'h0040_000c, 32'h0810_0000, 1'b1);

        // Redirect beats stall; low address bits are dropped
        bus.stall_i = 1;
        bus.redirect_valid = 1;
        bus.redirect_addr = 32'h0040_0001;
        step();
        chk_if("rd", 32'h0040_000c, 32'h0810_0000, 1'b0);
        bus.stall_i = 0;
        bus.redirect_valid = 0;
        step();
        chk_if("rd1", 32'h0040_0000, 32'h2008_0001, 1'b1);

        // Debug while running: one service, one bubble
        bus.dbg_req = 1;
        bus.dbg_addr = 32'h8;
        #1;
        chk("dbg.ma", bus.mem_address, 32'h8);
        step();
        chk("dbg.ack", {31'd0, bus.dbg_ack}, 32'd1);
        chk("dbg.dd", bus.dbg_data, 32'h0109_5020);
        chk_if("dbg", 32'h0040_0000, 32'h2008_0001, 1'b0);
        step();
        chk("dbg.ack2", {31'd0, bus.dbg_ack}, 32'd0);
        chk_if("dbg2", 32'h0040_0004, 32'h2009_0002, 1'b1);
        bus.dbg_req = 0;

        // Debug while stalled, out-of-range address reads as zero
        bus.stall_i = 1;
        bus.dbg_req = 1;
        bus.dbg_addr = 32'h80;
        step();
        chk("dso.ack", {31'd0, bus.dbg_ack}, 32'd1);
        chk("dso.dd", bus.dbg_data, 32'h0);
        chk_if("dso", 32'h0040_0004, 32'h2009_0002, 1'b1);
        bus.dbg_req = 0;
        step();
        chk("dso.ack2", {31'd0, bus.dbg_ack}, 32'd0);
        chk("dso.dd2", bus.dbg_data, 32'h0);
        bus.stall_i = 0;

        // Redirect past the ROM end raises the fault
        bus.redirect_valid = 1;
        bus.redirect_addr = 32'h0040_0080;
        step();
        chk("flt.pre", {31'd0, bus.fetch_fault}, 32'd0);
        bus.redirect_valid = 0;
        step();
        chk("flt", {31'd0, bus.fetch_fault}, 32'd1);
        chk_if("flt", 32'h0040_0004, 32'h0, 1'b0);
        chk("flt.ma", bus.mem_address, 32'h80);
        step();
        chk("flt2", {31'd0, bus.fetch_fault}, 32'd1);
        chk("flt2.ma", bus.mem_address, 32'h80);
        bus.redirect_valid = 1;
        bus.redirect_addr = 32'h0040_0000;
        step();
        chk("flt.clr", {31'd0, bus.fetch_fault}, 32'd0);
        bus.redirect_valid = 0;
        step();
        chk_if("res", 32'h0040_0000, 32'h2008_0001, 1'b1);

        // Below the reset vector the offset underflows
        bus.redirect_valid = 1;
        bus.redirect_addr = 32'h003F_FFFC;
        step();
        bus.redirect_valid = 0;
        step();
        chk("unf", {31'd0, bus.fetch_fault}, 32'd1);
        chk("unf.v", {31'd0, bus.instr_valid}, 32'd0);

        // Reset in the middle of a stall and pending debug request
        bus.stall_i = 1;
        bus.dbg_req = 1;
        bus.dbg_addr = 32'h4;
        reset = 1'b0;
        step();
        chk_if("mrst", 32'h0040_0000, 32'h0, 1'b0);
        chk("mrst.ack", {31'd0, bus.dbg_ack}, 32'd0);
        chk("mrst.dd", bus.dbg_data, 32'd0);
        chk("mrst.flt", {31'd0, bus.fetch_fault}, 32'd0);
        reset = 1'b1;
        bus.stall_i = 0;
        bus.dbg_req = 0;
        step();
        chk_if("mrst1", 32'h0040_0000, 32'h2008_0001, 1'b1);
        chk("mrst1.ack", {31'd0, bus.dbg_ack}, 32'd0);
        step();
        chk_if("mrst2", 32'h0040_0004, 32'h2009_0002, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/program_fetch_arbiter.md
Name: program_fetch_arbiter

Overview:
Owns the program counter and the single combinational read port of the program ROM. Each cycle it grants that port to either the core's instruction fetch or a debug/readback requester. Fetch is sequenced with stall and redirect (branch/jump) support, and the fetched instruction is registered into an IF output stage. It sits between the PC/branch logic of the MIPS core and the program ROM.

Parameters:
DATA_WIDTH, 32, width of addresses and instruction words
MEMORY_DEPTH, 32, number of ROM words; byte offsets at or above 4*MEMORY_DEPTH are out of range
RESET_VECTOR, 32'h0040_0000, PC value after reset; ROM byte offset 0 maps to this address

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
stall_i  in  1  hold the fetch stage (PC, instr_o, instr_valid frozen)
redirect_valid  in  1  load PC from redirect_addr this cycle; squashes the current fetch
redirect_addr  in  DATA_WIDTH  absolute branch/jump target
dbg_req  in  1  level request for a ROM read by the debug port
dbg_addr  in  DATA_WIDTH  debug ROM byte offset, held stable while dbg_req=1
dbg_ack  out  1  registered one-cycle pulse; dbg_data valid during this cycle
dbg_data  out  DATA_WIDTH  word read for the debug port
mem_address  out  DATA_WIDTH  combinational ROM byte offset; connects to the ROM address input
mem_instruction  in  DATA_WIDTH  combinational ROM data
pc_o  out  DATA_WIDTH  PC of the instruction in instr_o
instr_o  out  DATA_WIDTH  registered fetched instruction
instr_valid  out  1  instr_o holds a real instruction (0 = bubble)
fetch_fault  out  1  sticky flag: PC is out of ROM range

Behaviour:
- Reset values (reset=0 at a clk edge):
  - pc = RESET_VECTOR
  - pc_o = RESET_VECTOR
  - instr_o = 0
  - instr_valid = 0
  - dbg_ack = 0
  - dbg_data = 0
  - fetch_fault = 0
  - last_grant = FETCH
- Reset mid-operation: any pending debug request is dropped without an ack, and an in-flight redirect is lost.
- Grant is decided combinationally in the same cycle.
  - Debug is eligible when dbg_req=1 and dbg_ack=0. This prevents a double service while the requester drops its request.
  - Grant goes to DEBUG if debug is eligible and (stall_i=1, or last_grant=FETCH, or fetch_fault=1). Otherwise the grant goes to FETCH.
  - Consequence: fetch is never starved more than one cycle in a row while running. While stalled, debug may take every eligible cycle.
- mem_address:
  - Under a FETCH grant: pc - RESET_VECTOR.
  - Under a DEBUG grant: dbg_addr.
  - Bits [1:0] are forced to 0 in both cases.
- FETCH grant, per cycle, in priority order:
  - redirect_valid=1: pc <= {redirect_addr[31:2],2'b00}; instr_valid <= 0; fetch_fault <= 0. Redirect beats stall.
  - stall_i=1: all fetch registers hold.
  - Offset >= 4*MEMORY_DEPTH: instr_o <= 0 (NOP); instr_valid <= 0; fetch_fault <= 1; pc holds.
  - Otherwise: instr_o <= mem_instruction; pc_o <= pc; instr_valid <= 1; pc <= pc+4. Latency is one cycle from address to instr_o.
- DEBUG grant:
  - dbg_data <= mem_instruction, or 0 if dbg_addr is out of range.
  - dbg_ack <= 1 for exactly one cycle.
  - The fetch stage does not advance. If stall_i=0, instr_valid <= 0 (bubble) and instr_o/pc_o hold.
  - redirect_valid=1 during a DEBUG grant is still honoured: pc loads, instr_valid <= 0, fetch_fault clears.
- last_grant is updated every non-reset cycle. dbg_ack is 0 in every cycle it is not pulsed.
- PC arithmetic is modulo 2^DATA_WIDTH. Wrap-around is never specially handled; an underflowing offset is out of range and raises the fault.

Test Plan:
- Reset then run with ROM[0..3]=0x20080001,0x20090002,0x01095020,0x08100000 and no stall. Expected: instr_valid=1 from the 1st post-reset edge, pc_o 0x00400000, 0x00400004, …, and instr_o matches the words in order.
- stall_i=1 for 3 cycles after the second instruction. Expected: pc_o=0x00400004, instr_o=0x20090002 and instr_valid=1 held for 3 cycles; then 0x01095020 follows.
- redirect_valid=1 with redirect_addr=0x00400001 together with stall_i=1. Expected: next cycle instr_valid=0; the following cycle pc_o=0x00400000 and instr_o=0x20080001.
- dbg_req held with dbg_addr=0x8 while running. Expected: the DEBUG grant alternates with FETCH; dbg_ack pulses once with dbg_data=0x01095020; fetch inserts exactly one bubble.
- redirect_addr=0x00400080 with MEMORY_DEPTH=32. Expected: fetch_fault=1, instr_o=0, instr_valid=0, pc held. A later redirect to 0x00400000 clears the fault and fetch resumes.
- Assert reset=0 during a pending dbg_req and a stall. Expected: all outputs take their reset values on that edge, no dbg_ack, and fetch restarts at 0x00400000.
